// File: rtl/pkg_genius.sv
// Shared definitions for the Genius game: FSM state codes used by the playback
// sequencer and by the control unit's debug decoder, plus default display timing.
package pkg_genius;

    typedef enum logic [2:0] {
        S_OCIOSO  = 3'd0,
        S_CARREGA = 3'd1,
        S_ACENDE  = 3'd2,
        S_APAGA   = 3'd3,
        S_AVANCA  = 3'd4,
        S_FIM     = 3'd5
    } estado_t;

    localparam int T_ON_PADRAO  = 1000;
    localparam int T_OFF_PADRAO = 500;

endpackage

// File: rtl/contador_tempo.sv
// Up-counter that times the LED on/off phases; fim flags when the count
// reaches the compare value supplied by the FSM.
module contador_tempo #(
    parameter int CNT_W = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    input  logic [CNT_W-1:0] limite,
    output logic             fim
);

    logic [CNT_W-1:0] r_contagem;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (zera) begin
            r_contagem <= '0;
        end else if (conta) begin
            r_contagem <= r_contagem + CNT_W'(1);
        end
    end

    assign fim = (r_contagem == limite);

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// Playback sequencer: walks the sequence RAM from address 0 to the latched
// limit, flashing each stored move on the LEDs for T_ON cycles then blanking T_OFF.
module controle_exibicao_sequencia
    import pkg_genius::*;
#(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 11,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [3:0]        dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [3:0]        leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam logic [CNT_W-1:0] LIM_ACENDE = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] LIM_APAGA  = CNT_W'(T_OFF - 1);

    estado_t           r_estado;
    estado_t           w_proximo;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] r_lim_reg;
    logic              w_zera;
    logic              w_conta;
    logic              w_fim_tempo;
    logic [CNT_W-1:0]  w_limite_tempo;
    logic              w_inicio;
    logic              w_ultimo;

    assign w_inicio = (r_estado == S_OCIOSO) && iniciar && !abortar;
    // Compare before incrementing so the address never wraps past the limit.
    assign w_ultimo = (r_endereco == r_lim_reg);

    contador_tempo #(
        .CNT_W (CNT_W)
    ) u_contador_tempo (
        .clock  (clock),
        .reset  (reset),
        .zera   (w_zera),
        .conta  (w_conta),
        .limite (w_limite_tempo),
        .fim    (w_fim_tempo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= S_OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_proximo      = r_estado;
        w_zera         = 1'b0;
        w_conta        = 1'b0;
        w_limite_tempo = LIM_APAGA;
        case (r_estado)
            S_OCIOSO: begin
                if (w_inicio) w_proximo = S_CARREGA;
            end
            S_CARREGA: begin
                w_zera    = 1'b1;
                w_proximo = S_ACENDE;
            end
            S_ACENDE: begin
                w_limite_tempo = LIM_ACENDE;
                if (w_fim_tempo) begin
                    w_zera    = 1'b1;
                    w_proximo = S_APAGA;
                end else begin
                    w_conta = 1'b1;
                end
            end
            S_APAGA: begin
                if (w_fim_tempo) begin
                    w_zera    = 1'b1;
                    w_proximo = S_AVANCA;
                end else begin
                    w_conta = 1'b1;
                end
            end
            S_AVANCA: begin
                w_proximo = w_ultimo ? S_FIM : S_CARREGA;
            end
            S_FIM: begin
                w_proximo = S_OCIOSO;
            end
            default: begin
                w_proximo = S_OCIOSO;
            end
        endcase
        if (abortar) begin
            w_proximo = S_OCIOSO;
            w_zera    = 1'b1;
            w_conta   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_endereco <= '0;
            r_lim_reg  <= '0;
        end else if (w_inicio) begin
            r_endereco <= '0;
            r_lim_reg  <= limite;
        end else if ((r_estado == S_AVANCA) && !abortar && !w_ultimo) begin
            r_endereco <= r_endereco + ADDR_W'(1);
        end
    end

    always_comb begin
        leds = 4'b0000;
        if (r_estado == S_ACENDE) leds = dado_mem;
    end

    assign endereco  = r_endereco;
    assign ocupado   = (r_estado != S_OCIOSO);
    assign pronto    = (r_estado == S_FIM);
    assign db_estado = r_estado;

endmodule
